// File: rtl/mmio_interconnect.sv
// rtl/mmio_interconnect.sv - parametrised MMIO interconnect between the core data port and NUM_SLAVES peripherals
//
// Decodes the core address into one of NUM_SLAVES contiguous regions. Each access uses a registered
// request/ready handshake with per-slave wait states. Unresponsive slaves time out, and the block
// reports bus errors.
//
// Ports
//   clk, reset          clock; synchronous active-low reset
//   m_req/m_we          core request (held until m_ready) and write flag
//   m_addr/m_wdata      core byte address and write data
//   m_rdata/m_ready     read data and one-cycle completion pulse
//   m_err               bus error flag, valid with m_ready
//   s_sel/s_we          one-hot slave select and write strobe, held through ACCESS
//   s_addr/s_wdata      offset within the selected region and registered write data
//   s_rdata/s_ready     per-slave read data (packed) and done flags
//   err_count           saturating bus-error count
//   last_err_addr       address of the most recent bus error
module mmio_interconnect #(
  parameter int                    NUM_SLAVES  = 4,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h1001_0000,
  parameter int                    REGION_BITS = 8,
  parameter int                    TIMEOUT     = 15
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             m_req,
  input  logic                             m_we,
  input  logic [ADDR_WIDTH-1:0]            m_addr,
  input  logic [DATA_WIDTH-1:0]            m_wdata,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             m_ready,
  output logic                             m_err,
  output logic [NUM_SLAVES-1:0]            s_sel,
  output logic                             s_we,
  output logic [REGION_BITS-1:0]           s_addr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]            s_ready,
  output logic [7:0]                       err_count,
  output logic [ADDR_WIDTH-1:0]            last_err_addr
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t                  state;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [ADDR_WIDTH-1:0]   req_addr;

  logic [ADDR_WIDTH-1:0]   offset;
  logic [ADDR_WIDTH-1:0]   region;
  logic                    hit;
  logic [NUM_SLAVES-1:0]   onehot;
  logic [DATA_WIDTH-1:0]   rd_mux;
  logic                    sel_ready;

  // Address decode of the incoming request
  always_comb begin
    offset = m_addr - BASE_ADDR;
    region = offset >> REGION_BITS;
    hit    = (m_addr >= BASE_ADDR) && (region < ADDR_WIDTH'(NUM_SLAVES));
    onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (region == ADDR_WIDTH'(i)) onehot[i] = 1'b1;
    end
  end

  // Only the selected slave's ready and data are seen; s_sel is one-hot, so OR-ing masked lanes
  // picks exactly that slave and keeps every other s_ready bit out of the handshake.
  always_comb begin
    rd_mux    = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (s_sel[i]) begin
        rd_mux    = rd_mux | s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ready = sel_ready | s_ready[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      req_addr      <= '0;
      m_rdata       <= '0;
      m_ready       <= 1'b0;
      m_err         <= 1'b0;
      s_sel         <= '0;
      s_we          <= 1'b0;
      s_addr        <= '0;
      s_wdata       <= '0;
      err_count     <= '0;
      last_err_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          m_ready <= 1'b0;
          m_err   <= 1'b0;
          m_rdata <= '0;
          if (m_req) begin
            req_addr <= m_addr;
            tmo_cnt  <= '0;
            if (hit) begin
              s_sel   <= onehot;
              s_we    <= m_we;
              s_addr  <= offset[REGION_BITS-1:0];
              s_wdata <= m_wdata;
              state   <= ACCESS;
            end else begin
              m_err         <= 1'b1;
              last_err_addr <= m_addr;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              state         <= RESP;
            end
          end
        end

        ACCESS: begin
          // Ready is tested first so a slave answering on the expiry cycle still completes cleanly
          if (sel_ready) begin
            m_rdata <= s_we ? '0 : rd_mux;
            m_err   <= 1'b0;
            s_sel   <= '0;
            s_we    <= 1'b0;
            state   <= RESP;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            m_rdata       <= '0;
            m_err         <= 1'b1;
            s_sel         <= '0;
            s_we          <= 1'b0;
            last_err_addr <= req_addr;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            state         <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        RESP: begin
          // m_rdata/m_err were loaded on entry; they stay put for the m_ready cycle
          m_ready <= 1'b1;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_interconnect.sv
// tb/tb_mmio_interconnect.sv - randomized self-checking bench for mmio_interconnect
module tb_mmio_interconnect;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int          TMO  = 15;
  localparam int          NEVER = 1000;

  logic         clk;
  logic         reset;
  logic         m_req;
  logic         m_we;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [31:0]  m_rdata;
  logic         m_ready;
  logic         m_err;
  logic [3:0]   s_sel;
  logic         s_we;
  logic [7:0]   s_addr;
  logic [31:0]  s_wdata;
  logic [127:0] s_rdata;
  logic [3:0]   s_ready;
  logic [7:0]   err_count;
  logic [31:0]  last_err_addr;

  int errors = 0;
  int checks = 0;

  logic [31:0] slave_mem [4][256];
  logic [31:0] ref_mem [logic [31:0]];
  int          ref_err;
  logic [31:0] ref_last;

  mmio_interconnect #(
    .NUM_SLAVES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .BASE_ADDR(BASE), .REGION_BITS(8), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .err_count(err_count), .last_err_addr(last_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) s_rdata[i*32 +: 32] = slave_mem[i][s_addr];
  end

  // One complete transaction with a slave that holds s_ready low for w ACCESS cycles
  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input int w, input bit rand_others);
    logic [31:0] off;
    int          idx;
    bit          hit, ok, done;
    int          exp_lat, exp_acc, lat, acc, strobes;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rdata;
    off     = addr - BASE;
    idx     = int'(off >> 8);
    hit     = (addr >= BASE) && (off < 32'd1024);
    ok      = hit && (w < TMO);
    exp_lat = !hit ? 1 : (ok ? 2 + w : 1 + TMO);
    exp_acc = !hit ? 0 : (ok ? w + 1 : TMO);
    exp_sel = hit ? 4'(1 << idx) : 4'b0000;
    exp_rdata = (ok && !we) ? ref_mem[addr] : 32'h0;
    if (ok && we) ref_mem[addr] = wdata;
    if (!ok) begin
      ref_err  = (ref_err >= 255) ? 255 : ref_err + 1;
      ref_last = addr;
    end

    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata;
    lat = -1; acc = 0; strobes = 0; done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(posedge clk); #1;
      if (m_ready) begin
        lat  = n;
        done = 1;
      end else if (s_sel != 4'b0000) begin
        acc++;
        checks++;
        if (s_sel !== exp_sel || s_we !== we || s_addr !== off[7:0] || (we && s_wdata !== wdata)) begin
          errors++;
          $display("FAIL access_outputs addr=%h: sel=%b we=%b saddr=%h wdata=%h, required sel=%b we=%b saddr=%h wdata=%h",
                   addr, s_sel, s_we, s_addr, s_wdata, exp_sel, we, off[7:0], wdata);
        end
        s_ready = rand_others ? 4'($urandom) : 4'hF;
        if (hit) begin
          if (acc > w) begin
            s_ready[idx] = 1'b1;
            if (we && s_sel[idx]) begin
              strobes++;
              slave_mem[idx][s_addr] = s_wdata;
            end
          end else begin
            s_ready[idx] = 1'b0;
          end
        end
      end
    end
    m_req = 1'b0;

    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency addr=%h: got %0d edges, required %0d", addr, lat, exp_lat);
    end
    if (done) begin
      checks++;
      if (m_err !== !ok || m_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL response addr=%h: err=%b rdata=%h, required err=%b rdata=%h",
                 addr, m_err, m_rdata, !ok, exp_rdata);
      end
      checks++;
      if (err_count !== 8'(ref_err) || last_err_addr !== ref_last) begin
        errors++;
        $display("FAIL err_stats addr=%h: count=%0d last=%h, required count=%0d last=%h",
                 addr, err_count, last_err_addr, ref_err, ref_last);
      end
      checks++;
      if (acc != exp_acc || strobes != ((ok && we) ? 1 : 0)) begin
        errors++;
        $display("FAIL access_len addr=%h: sel cycles=%0d strobes=%0d, required %0d and %0d",
                 addr, acc, strobes, exp_acc, (ok && we) ? 1 : 0);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (m_ready !== 1'b0 || s_sel !== 4'b0000 || m_err !== 1'b0 || m_rdata !== 32'h0) begin
      errors++;
      $display("FAIL idle_after addr=%h: ready=%b sel=%b err=%b rdata=%h, required all zero",
               addr, m_ready, s_sel, m_err, m_rdata);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (m_rdata !== 32'h0 || m_ready !== 1'b0 || m_err !== 1'b0 || s_sel !== 4'b0 || s_we !== 1'b0 ||
        s_addr !== 8'h0 || s_wdata !== 32'h0 || err_count !== 8'h0 || last_err_addr !== 32'h0) begin
      errors++;
      $display("FAIL %s: rdata=%h ready=%b err=%b sel=%b we=%b saddr=%h swdata=%h cnt=%0d last=%h, required all zero",
               name, m_rdata, m_ready, m_err, s_sel, s_we, s_addr, s_wdata, err_count, last_err_addr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    reset = 1'b1;
    @(posedge clk); #1;
    ref_err = 0; ref_last = 32'h0;
  endtask

  task automatic test_zero_wait_read();
    slave_mem[1][8'h04] = 32'hCAFE_0001;
    ref_mem[32'h1001_0104] = 32'hCAFE_0001;
    do_txn(32'h1001_0104, 1'b0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_wait_write();
    do_txn(32'h1001_0200, 1'b1, 32'h0000_005A, 3, 1'b0);
    do_txn(32'h1001_0200, 1'b0, 32'h0, 1, 1'b0);
  endtask

  task automatic test_decode_miss();
    do_txn(32'h1001_0400, 1'b0, 32'h0, 0, 1'b0);
    do_txn(32'h0000_0010, 1'b0, 32'h0, 0, 1'b0);
    checks++;
    if (err_count !== 8'd2 || last_err_addr !== 32'h0000_0010) begin
      errors++;
      $display("FAIL miss_stats: count=%0d last=%h, required 2 and 00000010", err_count, last_err_addr);
    end
  endtask

  task automatic test_timeout();
    do_txn(32'h1001_0310, 1'b0, 32'h0, NEVER, 1'b0);
    do_txn(32'h1001_0310, 1'b0, 32'h0, TMO - 1, 1'b0);
    do_txn(32'h1001_0314, 1'b1, 32'h1234_5678, NEVER, 1'b0);
  endtask

  task automatic test_isolation();
    do_txn(32'h1001_0020, 1'b0, 32'h0, 4, 1'b0);
    do_txn(32'h1001_0024, 1'b0, 32'h0, 6, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          w;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE + ($urandom_range(0, 1023) & 32'hFFFF_FFFC);
      w = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 5));
      do_txn(a, 1'($urandom), $urandom, w, 1'b1);
    end
  endtask

  task automatic test_saturation();
    for (int t = 0; t < 300; t++) do_txn(32'h2000_0000 + 32'(t), 1'b0, 32'h0, 0, 1'b0);
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL saturation: count=%0d, required 255", err_count);
    end
  endtask

  task automatic test_reset_mid_access();
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h1001_0110; m_wdata = 32'h0;
    s_ready = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_sel !== 4'b0010) begin
      errors++;
      $display("FAIL mid_access_sel: sel=%b, required 0010", s_sel);
    end
    reset = 1'b0; m_req = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset_mid_access");
    reset = 1'b1;
    ref_err = 0; ref_last = 32'h0;
    s_ready = 4'hF;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      checks++;
      if (m_ready !== 1'b0) begin
        errors++;
        $display("FAIL no_ready_after_reset: ready=%b, required 0", m_ready);
      end
    end
    do_txn(32'h1001_0110, 1'b0, 32'h0, 2, 1'b0);
  endtask

  initial begin
    reset = 1'b0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; s_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 256; j++) begin
        slave_mem[i][j] = $urandom;
        ref_mem[BASE + 32'(i * 256 + j)] = slave_mem[i][j];
      end
    end
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_decode_miss();
    test_timeout();
    test_isolation();
    test_random();
    test_saturation();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
